// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the response-path state types.
// Imported by the response mux and its default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    typedef enum logic [1:0] {
        TO_RUN = 2'd0,
        TO1    = 2'd1,
        TO2    = 2'd2
    } to_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR for active transfers to unmapped space.
// Zero latency; first ERROR cycle is driven in the data phase itself.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic ahb_clk_in,
    input  logic ahb_rstn_in,
    input  logic active,
    input  logic trans,
    output logic hready,
    output logic hresp
);

    ds_state_e r_state;
    ds_state_e w_cur;
    ds_state_e w_next;

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ERR1 is never held in the register: it is the IDLE cycle that sees the
    // erroneous transfer, so the pair completes two cycles after the address.
    always_comb begin
        w_cur = r_state;
        if (r_state == DS_IDLE && active && trans) begin
            w_cur = DS_ERR1;
        end
        case (w_cur)
            DS_ERR1: w_next = DS_ERR2;
            default: w_next = DS_IDLE;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (r_state)
            DS_IDLE: begin
                if (active && trans) begin
                    hready = 1'b0;
                    hresp  = HRESP_ERROR;
                end
            end
            DS_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            DS_ERR2: begin
                hready = 1'b1;
                hresp  = HRESP_ERROR;
            end
            default: begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response mux with built-in default slave; zero-latency routing.
// Stalls follow the selected slave; AHB_RESP_TIMEOUT_EN adds a forced-ERROR abort.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int SLAVE_DEVICES  = 4,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                    ahb_clk_in,
    input  logic                                    ahb_rstn_in,
    input  logic [SLAVE_DEVICES:0]                  slave_sel_in,
    input  logic [1:0]                              htrans_in,
    input  logic [SLAVE_DEVICES-1:0]                slv_hreadyout_in,
    input  logic [SLAVE_DEVICES-1:0]                slv_hresp_in,
    input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slv_hrdata_in,
    output logic                                    hready_out,
    output logic                                    hresp_out,
    output logic [AHB_DATA_WIDTH-1:0]               hrdata_out,
    output logic                                    timeout_flag_out
);

    localparam logic [SLAVE_DEVICES:0] SEL_ONE = {{SLAVE_DEVICES{1'b0}}, 1'b1};

    logic [SLAVE_DEVICES:0]    r_dsel;
    logic                      r_dtrans;
    logic                      w_trans_act;
    logic                      w_none;
    logic                      w_onehot;
    logic                      w_def_act;
    logic                      w_slv_act;
    logic                      w_slv_rdy;
    logic                      w_slv_resp;
    logic [AHB_DATA_WIDTH-1:0] w_slv_dat;
    logic                      w_ds_rdy;
    logic                      w_ds_resp;
    logic                      w_to_force;
    logic                      w_to_rdy;

    assign w_trans_act = (htrans_in == HTRANS_NONSEQ) || (htrans_in == HTRANS_SEQ);

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            r_dsel   <= '0;
            r_dtrans <= 1'b0;
        end else if (hready_out) begin
            r_dsel   <= slave_sel_in;
            r_dtrans <= w_trans_act;
        end
    end

    // Illegal multi-hot selects fall onto the default slave.
    assign w_none    = (r_dsel == '0);
    assign w_onehot  = ((r_dsel & (r_dsel - SEL_ONE)) == '0);
    assign w_def_act = !w_none && (r_dsel[0] || !w_onehot);
    assign w_slv_act = !w_none && !w_def_act;

    always_comb begin
        w_slv_rdy  = |(r_dsel[SLAVE_DEVICES:1] & slv_hreadyout_in);
        w_slv_resp = |(r_dsel[SLAVE_DEVICES:1] & slv_hresp_in);
        w_slv_dat  = '0;
        for (int k = 0; k < SLAVE_DEVICES; k++) begin
            if (r_dsel[k+1]) begin
                w_slv_dat = w_slv_dat | slv_hrdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    ahb_default_slave u_default_slave (
        .ahb_clk_in  (ahb_clk_in),
        .ahb_rstn_in (ahb_rstn_in),
        .active      (w_def_act),
        .trans       (r_dtrans),
        .hready      (w_ds_rdy),
        .hresp       (w_ds_resp)
    );

`ifdef AHB_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    to_state_e        r_to_state;
    to_state_e        w_to_next;
    logic [CNT_W-1:0] r_to_cnt;
    logic             w_stall;
    logic             w_limit;
    logic             w_to_flag;

    assign w_stall = w_slv_act && r_dtrans && !w_slv_rdy && (r_to_state == TO_RUN);
    assign w_limit = w_stall && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            r_to_cnt <= '0;
        end else if (hready_out || !w_stall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            r_to_state <= TO_RUN;
        end else begin
            r_to_state <= w_to_next;
        end
    end

    always_comb begin
        w_to_next = r_to_state;
        case (r_to_state)
            TO_RUN:  w_to_next = w_limit ? TO1 : TO_RUN;
            TO1:     w_to_next = TO2;
            default: w_to_next = TO_RUN;
        endcase
    end

    always_comb begin
        w_to_force = 1'b0;
        w_to_rdy   = 1'b1;
        w_to_flag  = 1'b0;
        case (r_to_state)
            TO1: begin
                w_to_force = 1'b1;
                w_to_rdy   = 1'b0;
                w_to_flag  = 1'b1;
            end
            TO2: begin
                w_to_force = 1'b1;
                w_to_rdy   = 1'b1;
            end
            default: begin
                w_to_force = 1'b0;
                w_to_rdy   = 1'b1;
            end
        endcase
    end

    assign timeout_flag_out = w_to_flag;
`else
    assign w_to_force       = 1'b0;
    assign w_to_rdy         = 1'b1;
    assign timeout_flag_out = 1'b0;
`endif

    always_comb begin
        hready_out = 1'b1;
        hresp_out  = HRESP_OKAY;
        hrdata_out = '0;
        if (w_to_force) begin
            hready_out = w_to_rdy;
            hresp_out  = HRESP_ERROR;
        end else if (w_def_act) begin
            hready_out = w_ds_rdy;
            hresp_out  = w_ds_resp;
        end else if (w_slv_act) begin
            hready_out = w_slv_rdy;
            hresp_out  = w_slv_resp;
            hrdata_out = w_slv_dat;
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: routing vector table plus multi-cycle sequences.
module tb_ahb_resp_mux;

    logic         clk;
    logic         rstn;
    logic [4:0]   sel;
    logic [1:0]   trans;
    logic [3:0]   rdy;
    logic [3:0]   resp;
    logic [127:0] rdata;
    logic         hready;
    logic         hresp;
    logic [31:0]  hrdata;
    logic         flag;

    int errors;
    int checks;

    ahb_resp_mux #(
        .SLAVE_DEVICES  (4),
        .AHB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .ahb_clk_in       (clk),
        .ahb_rstn_in      (rstn),
        .slave_sel_in     (sel),
        .htrans_in        (trans),
        .slv_hreadyout_in (rdy),
        .slv_hresp_in     (resp),
        .slv_hrdata_in    (rdata),
        .hready_out       (hready),
        .hresp_out        (hresp),
        .hrdata_out       (hrdata),
        .timeout_flag_out (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        logic [1:0]  trans;
        logic [3:0]  rdy;
        logic [3:0]  resp;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_dat;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input logic e_rdy, input logic e_resp);
        chk({nm, ".hready"}, {31'd0, hready}, {31'd0, e_rdy});
        chk({nm, ".hresp"}, {31'd0, hresp}, {31'd0, e_resp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] BASE_DATA =
        {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{5'b00010, 2'b10, 4'hF, 4'h0, 1'b1, 1'b0, 32'hAAAA_0000, "s0_nonseq"};
        vecs[1]  = '{5'b00100, 2'b11, 4'hF, 4'h0, 1'b1, 1'b0, 32'hBBBB_0001, "s1_seq"};
        vecs[2]  = '{5'b01000, 2'b10, 4'hB, 4'h0, 1'b0, 1'b0, 32'hCCCC_0002, "s2_wait"};
        vecs[3]  = '{5'b10000, 2'b10, 4'hF, 4'h8, 1'b1, 1'b1, 32'hDDDD_0003, "s3_err"};
        vecs[4]  = '{5'b10000, 2'b00, 4'h7, 4'h0, 1'b0, 1'b0, 32'hDDDD_0003, "s3_idle_pass"};
        vecs[5]  = '{5'b00001, 2'b00, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0,         "def_idle"};
        vecs[6]  = '{5'b00001, 2'b01, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0,         "def_busy"};
        vecs[7]  = '{5'b00001, 2'b10, 4'hF, 4'h0, 1'b0, 1'b1, 32'h0,         "def_nonseq"};
        vecs[8]  = '{5'b00110, 2'b10, 4'hF, 4'h0, 1'b0, 1'b1, 32'h0,         "multihot"};
        vecs[9]  = '{5'b00000, 2'b10, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0,         "no_target"};
        vecs[10] = '{5'b00011, 2'b00, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0,         "multihot_idle"};

        rstn  = 1'b0;
        sel   = 5'b00001;
        trans = 2'b10;
        rdy   = 4'hF;
        resp  = 4'h0;
        rdata = BASE_DATA;

        // Reset state, with an erroneous-looking request presented
        #1;
        chk_bus("rst", 1'b1, 1'b0);
        chk("rst.hrdata", hrdata, 32'h0);
        chk("rst.flag", {31'd0, flag}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_bus("rst_edge", 1'b1, 1'b0);
        sel   = 5'b00000;
        trans = 2'b00;
        tick();
        rstn = 1'b1;
        tick();

        // Table-driven routing: address phase, then data phase check
        for (int i = 0; i < 11; i++) begin
            sel   = vecs[i].sel;
            trans = vecs[i].trans;
            tick();
            sel   = 5'b00000;
            trans = 2'b00;
            rdy   = vecs[i].rdy;
            resp  = vecs[i].resp;
            @(negedge clk);
            chk_bus(vecs[i].name, vecs[i].e_rdy, vecs[i].e_resp);
            chk({vecs[i].name, ".hrdata"}, hrdata, vecs[i].e_dat);
            tick();
            rdy  = 4'hF;
            resp = 4'h0;
            tick();
            tick();
        end

        // Read from slave 1 with one wait state
        rdata[63:32] = 32'hA5A5_0001;
        sel   = 5'b00100;
        trans = 2'b10;
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        rdy   = 4'hD;
        @(negedge clk);
        chk_bus("rd_wait", 1'b0, 1'b0);
        tick();
        rdy = 4'hF;
        @(negedge clk);
        chk_bus("rd_done", 1'b1, 1'b0);
        chk("rd_done.hrdata", hrdata, 32'hA5A5_0001);
        tick();
        rdata = BASE_DATA;
        @(negedge clk);
        chk_bus("rd_after", 1'b1, 1'b0);
        tick();

        // Back-to-back unmapped NONSEQ: two ERROR pairs with no gap
        sel   = 5'b00001;
        trans = 2'b10;
        tick();
        @(negedge clk);
        chk_bus("b2b_p1c1", 1'b0, 1'b1);
        tick();
        @(negedge clk);
        chk_bus("b2b_p1c2", 1'b1, 1'b1);
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        @(negedge clk);
        chk_bus("b2b_p2c1", 1'b0, 1'b1);
        tick();
        @(negedge clk);
        chk_bus("b2b_p2c2", 1'b1, 1'b1);
        tick();
        @(negedge clk);
        chk_bus("b2b_done", 1'b1, 1'b0);
        tick();

        // Reset asserted during the first ERROR cycle
        sel   = 5'b00001;
        trans = 2'b10;
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        @(negedge clk);
        chk_bus("mid_err1", 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk_bus("mid_rst", 1'b1, 1'b0);
        chk("mid_rst.hrdata", hrdata, 32'h0);
        chk("mid_rst.flag", {31'd0, flag}, 32'h0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk_bus("post_rst", 1'b1, 1'b0);
        tick();

`ifdef AHB_RESP_TIMEOUT_EN
        // Slave 0 stalls past the limit: four pass-through stalls, then TO1/TO2
        sel   = 5'b00010;
        trans = 2'b10;
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        rdy   = 4'hE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_bus($sformatf("to_stall%0d", c), 1'b0, 1'b0);
            chk($sformatf("to_stall%0d.flag", c), {31'd0, flag}, 32'h0);
            tick();
        end
        @(negedge clk);
        chk_bus("to1", 1'b0, 1'b1);
        chk("to1.flag", {31'd0, flag}, 32'h1);
        tick();
        @(negedge clk);
        chk_bus("to2", 1'b1, 1'b1);
        chk("to2.flag", {31'd0, flag}, 32'h0);
        tick();
        rdy = 4'hF;
        @(negedge clk);
        chk_bus("to_after", 1'b1, 1'b0);
        tick();

        // Slave 0 becomes ready on the limit cycle: normal completion
        sel   = 5'b00010;
        trans = 2'b10;
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        rdy   = 4'hE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_bus($sformatf("lim_stall%0d", c), 1'b0, 1'b0);
            tick();
        end
        rdy = 4'hF;
        @(negedge clk);
        chk_bus("lim_done", 1'b1, 1'b0);
        chk("lim_done.hrdata", hrdata, 32'hAAAA_0000);
        chk("lim_done.flag", {31'd0, flag}, 32'h0);
        tick();
        @(negedge clk);
        chk_bus("lim_after", 1'b1, 1'b0);
        chk("lim_after.flag", {31'd0, flag}, 32'h0);
        tick();
`else
        // Without the timeout a stall lasts as long as the slave holds it
        sel   = 5'b00010;
        trans = 2'b10;
        tick();
        sel   = 5'b00000;
        trans = 2'b00;
        rdy   = 4'hE;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk_bus($sformatf("stall%0d", c), 1'b0, 1'b0);
            chk($sformatf("stall%0d.flag", c), {31'd0, flag}, 32'h0);
            tick();
        end
        rdy = 4'hF;
        @(negedge clk);
        chk_bus("stall_done", 1'b1, 1'b0);
        chk("stall_done.hrdata", hrdata, 32'hAAAA_0000);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
